vc_switch_arbiter: RTL
======================

VC_SWITCH_ARBITER -- requirements
Module: vc_switch_arbiter

Interface
REQ-001 Parameter CREDITS, default 4: downstream buffer slots per VC (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 vc0_valid, vc0_head, vc0_tail  input  1 each  VC0 front-flit status.
REQ-005 vc1_valid, vc1_head, vc1_tail  input  1 each  VC1 front-flit status.
REQ-006 out_ready  input  1  downstream accepts a flit this cycle.
REQ-007 credit_in  input  2  bit i: one slot freed in downstream VCi buffer.
REQ-008 selected_vc  output  2  to the switch: 2'b00 = VC0, 2'b01 = VC1, 2'b11 = none.
REQ-009 xfer  output  1  a flit moves through the switch this cycle.
REQ-010 busy  output  1  a packet currently holds the switch.
REQ-011 credit0, credit1  output  4 each  current credit counts.

Function
REQ-012 The FSM SHALL have three states: IDLE, LOCK0 and LOCK1. selected_vc SHALL be 2'b11 in IDLE, 2'b00 in LOCK0 and 2'b01 in LOCK1. busy = (state != IDLE).
REQ-013 In IDLE, reqX SHALL be vcX_valid & vcX_head & (creditX > 0).
REQ-014 In IDLE with a single request, the FSM SHALL move to LOCKX on the next edge.
REQ-015 In IDLE with both requests, priority pointer prio (reset 0) SHALL select the VC: prio=0 grants VC0, prio=1 grants VC1.
REQ-016 The grant SHALL take one cycle; no flit is transferred in the IDLE cycle.
REQ-017 In LOCKX, xfer SHALL be vcX_valid & out_ready & (creditX > 0); it is combinational.
REQ-018 A stalled LOCKX (xfer=0) SHALL hold state indefinitely; the other VC SHALL NOT interleave flits.
REQ-019 xfer with vcX_tail=1 in LOCKX SHALL return the FSM to IDLE and set prio to the other VC (round-robin at packet granularity).
REQ-020 A single-flit packet (head & tail) SHALL lock for exactly one transfer cycle.
REQ-021 A head flit arriving on the locked VC before its tail SHALL be transferred as data; the FSM SHALL NOT re-arbitrate.
REQ-022 Credits: creditX SHALL decrement by 1 on xfer from VCX and increment by 1 on credit_in[X]. Both in one cycle leaves it unchanged.
REQ-023 An increment at creditX == CREDITS SHALL be ignored (saturating). The count SHALL never underflow, because xfer requires a nonzero count.
REQ-024 Flit throughput: after the grant cycle, 1 flit/cycle while valid, ready and credit hold.

Reset
REQ-025 While reset_n=0: state=IDLE, prio=0, selected_vc=2'b11, busy=0, credit0=credit1=CREDITS.
REQ-026 reset_n assertion mid-packet SHALL abort the lock immediately. After release, the FSM SHALL re-arbitrate from IDLE with credits restored.
REQ-027 xfer SHALL be 0 while reset_n=0.

Configuration
REQ-028 Macro VC_ARB_CREDIT_EN defined: credit counters SHALL be compiled in and gate requests and transfers per REQ-013/017/022/023.
REQ-029 Macro VC_ARB_CREDIT_EN undefined: counters SHALL be removed. The creditX>0 terms SHALL be treated as 1, credit_in SHALL be ignored, and credit0/credit1 SHALL read 0.

Verification
REQ-030 Reset release, vc0 3-flit packet (H,-,T), out_ready=1 -> selected_vc=00 on cycle 1, xfer on cycles 1-3, IDLE on cycle 4, credit0=1.
REQ-031 Both VCs request 1-flit packets back-to-back, prio=0 -> grant order VC0, VC1, VC0, VC1; selected_vc alternates 00/01 with an 11 cycle between.
REQ-032 LOCK1 mid-packet with out_ready=0 for 5 cycles while vc0 requests -> selected_vc stays 01, xfer=0, no VC0 grant until VC1 tail.
REQ-033 CREDITS=4, vc0 sends 4 flits with no credit_in -> credit0=0, xfer stalls with vc0_valid=1. credit_in[0] pulse -> next cycle xfer=1.
REQ-034 credit0=4 with credit_in[0]=1 -> stays 4. xfer and credit_in[0] in the same cycle -> count unchanged.
REQ-035 reset_n low during LOCK0 after 2 of 4 flits -> selected_vc=11 and credits=CREDITS immediately. Without VC_ARB_CREDIT_EN, the REQ-033 stimulus sends all flits without stalling.

Source files
------------

// File: rtl/vc_switch_arbiter_if.sv
// vc_switch_arbiter_if: flit status, handshake and credit bundle between VC buffers, arbiter and switch
// Signals: vcX_valid/head/tail, out_ready, credit_in[1:0] toward the arbiter;
//          selected_vc[1:0], xfer, busy, credit0/credit1[3:0] from the arbiter.
interface vc_switch_arbiter_if;
  logic vc0_valid, vc0_head, vc0_tail;
  logic vc1_valid, vc1_head, vc1_tail;
  logic out_ready;
  logic [1:0] credit_in;
  logic [1:0] selected_vc;
  logic xfer, busy;
  logic [3:0] credit0, credit1;
  modport master (
    output vc0_valid, vc0_head, vc0_tail, vc1_valid, vc1_head, vc1_tail, out_ready, credit_in,
    input selected_vc, xfer, busy, credit0, credit1
  );
  modport slave (
    input vc0_valid, vc0_head, vc0_tail, vc1_valid, vc1_head, vc1_tail, out_ready, credit_in,
    output selected_vc, xfer, busy, credit0, credit1
  );
endinterface

// File: rtl/vc_switch_arbiter.sv
// vc_switch_arbiter: two-VC packet-locked round-robin switch arbiter with optional downstream credits
// Ports: clk; reset_n (async assert, active-low); bus (vc_switch_arbiter_if.slave).
// Define VC_ARB_CREDIT_EN to compile in the per-VC credit counters; otherwise credits read 0 and never gate.
module vc_switch_arbiter #(
  parameter int CREDITS = 4
) (
  input logic clk,
  input logic reset_n,
  vc_switch_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2;
  logic [1:0] state, state_nx;
  logic prio, ok0, ok1, req0, req1, tail;
`ifdef VC_ARB_CREDIT_EN
  localparam logic [3:0] MAX = 4'(CREDITS);
  logic [3:0] c0, c1;
  logic x0, x1;
  assign ok0 = c0 != '0;
  assign ok1 = c1 != '0;
  assign x0 = bus.xfer & (state == LOCK0);
  assign x1 = bus.xfer & (state == LOCK1);
  // A send and a returned credit in the same cycle cancel, even at full count
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      c0 <= MAX;
      c1 <= MAX;
    end else begin
      c0 <= (x0 & ~bus.credit_in[0]) ? c0 - 4'd1 : (~x0 & bus.credit_in[0] & (c0 != MAX)) ? c0 + 4'd1 : c0;
      c1 <= (x1 & ~bus.credit_in[1]) ? c1 - 4'd1 : (~x1 & bus.credit_in[1] & (c1 != MAX)) ? c1 + 4'd1 : c1;
    end
  assign bus.credit0 = c0;
  assign bus.credit1 = c1;
`else
  logic unused_credit;
  assign unused_credit = ^{bus.credit_in, 4'(CREDITS)};
  assign ok0 = 1'b1;
  assign ok1 = 1'b1;
  assign bus.credit0 = '0;
  assign bus.credit1 = '0;
`endif
  assign req0 = bus.vc0_valid & bus.vc0_head & ok0;
  assign req1 = bus.vc1_valid & bus.vc1_head & ok1;
  assign bus.xfer = (state == LOCK0) ? bus.vc0_valid & bus.out_ready & ok0 :
                    (state == LOCK1) ? bus.vc1_valid & bus.out_ready & ok1 : 1'b0;
  assign tail = (state == LOCK0) ? bus.vc0_tail : bus.vc1_tail;
  assign bus.selected_vc = (state == LOCK0) ? 2'b00 : (state == LOCK1) ? 2'b01 : 2'b11;
  assign bus.busy = state != IDLE;
  // Heads seen while locked are plain data; only a transferred tail releases the switch
  always_comb
    state_nx = (state == IDLE) ? ((req0 & (~req1 | ~prio)) ? LOCK0 : req1 ? LOCK1 : IDLE) :
               (bus.xfer & tail) ? IDLE : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      prio <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.xfer & tail) prio <= state == LOCK0;
    end
endmodule
